toom8_interp_sequencer: RTL and testbench
=========================================

# toom8_interp_sequencer

- Sequential, resource-shared implementation of the Toom-8 interpolation step.
- Accepts the 15 evaluated point products p0..p14 as a stream and computes each scaled coefficient c_k = Σ_j C[k][j]·p_j, for k = 0..14.
- Uses one signed multiplier and one accumulator, driven by a row/column FSM; C[k][j] is read from an external coefficient ROM.
- Sits between the pointwise-multiply stage and the final divide/recombine stage. It is the low-area alternative to the fully parallel interpolation datapath.

## Interface
- PW, 310: width of point values (p inputs sign-extended to PW).
- CW, 64: width of signed scaled coefficients C[k][j].
- AW, 384: accumulator and output width.
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  point value present on in_data.
- in_ready  output  1  sequencer accepts a point this cycle.
- in_data  input  PW  signed point value; arrival order p0, p1, …, p14.
- coef_addr  output  8  ROM address = k*15 + j (0..224).
- coef_data  input  CW  signed C[k][j]; valid exactly one cycle after coef_addr.
- out_valid  output  1  out_data holds c_k.
- out_ready  input  1  downstream accepts c_k.
- out_idx  output  4  k of the current output (0..14).
- out_data  output  AW  signed c_k (scaled).
- busy  output  1  high in any state other than LOAD.

## Operation
- States: LOAD, MAC, DRAIN, OUT.
- Counters:
  - ld_cnt (0..15), counts points accepted.
  - row k (0..14).
  - col j (0..14), plus a one-cycle delayed copy j_d.
- Point register file: 15 × PW.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready stores in_data into point[ld_cnt] and increments ld_cnt.
  - On the acceptance of p14: k←0, j←0, next state MAC.
  - in_valid while in_ready=0 is ignored; no data is stored.
- MAC:
  - Each cycle drives coef_addr=k*15+j and increments j.
  - Once j has covered 14, next state DRAIN.
- Data-return cycle (MAC with j≥1, or DRAIN):
  - product = coef_data × point[j_d], computed at full signed CW+PW width and sign-extended to AW.
  - j_d=0: acc←product, which clears the previous row.
  - Otherwise: acc←acc+product.
  - Arithmetic wraps modulo 2^AW; no saturation or overflow flag.
- DRAIN:
  - Performs the final accumulate for j_d=14.
  - Next state OUT.
- OUT:
  - out_valid=1, out_idx=k, out_data=acc.
  - When out_ready=1: if k=14, go to LOAD with ld_cnt←0; otherwise k←k+1, j←0, go to MAC.
  - While out_ready=0, out_valid, out_idx, out_data and coef_addr hold unchanged.
- coef_addr=0 in LOAD and OUT; it holds its last MAC value during DRAIN.
- Point register contents are retained after a block completes and are overwritten on the next load.

## Timing
- Reset values:
  - state=LOAD, in_ready=1, busy=0, out_valid=0.
  - out_idx=0, out_data=0, coef_addr=0.
  - acc=0, all counters=0.
  - Point registers are not reset.
- Reset mid-operation aborts the current block. The cycle after rst deasserts is LOAD with in_ready=1.
- Load: one point per cycle at full rate; minimum load time is 15 cycles.
- p14 accepted at edge E:
  - MAC for row 0 occupies cycles E+1..E+15, with coef_addr 0..14 in order.
  - DRAIN is at E+16.
  - out_valid rises at E+17.
- With out_ready held high:
  - Each row takes 17 cycles.
  - c14 is presented at E+17+14·17 = E+255.
  - LOAD is re-entered at E+256.
- Handshake: a transfer occurs only on a cycle with out_valid&&out_ready.
  - out_valid is never deasserted without a transfer, except by rst.
- rst and in_valid in the same cycle: rst wins; no point is stored.

## Test plan
- Identity ROM (C[k][j]=1 if j=k, else 0), p_j=j+1 → fifteen outputs in order, out_idx 0..14, out_data=k+1 each.
- ROM all 6227020800, all p_j=1 → every out_data = 93405312000; the first out_valid is 17 cycles after p14 is accepted, and coef_addr runs 0..14 during row 0.
- Sign/width check: C[3][13]=−1, all other C entries 0, p13=−2^309 → c3=+2^309 exactly; all other c_k=0.
- Backpressure: out_ready low for 10 cycles at k=3 → out_data, out_idx and coef_addr stable throughout; the row-4 MAC starts the cycle after out_ready rises; all results match the ROM/point reference.
- Input gaps: in_valid toggling 1,0,1,0 during load → only valid cycles are stored; results are identical to a back-to-back load.
- Reset asserted during the row-5 MAC → next cycle out_valid=0, in_ready=1, busy=0; a fresh 15-point load produces a full correct 15-output block with no stale accumulator contribution.

Source files
------------

// File: rtl/toom8_interp_sequencer.sv
// Toom-8 interpolation sequencer: loads 15 point products, then computes
// c_k = sum_j C[k][j] * p_j for k = 0..14 using one signed multiplier and
// one accumulator. C[k][j] comes from an external ROM with one cycle of
// read latency.
module toom8_interp_sequencer #(
    parameter int PW = 310,
    parameter int CW = 64,
    parameter int AW = 384
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic [7:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_idx,
    output logic [AW-1:0] out_data,
    output logic          busy
);

    typedef enum logic [1:0] {LOAD, MAC, DRAIN, OUT} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          ld_cnt_reg, ld_cnt_next;
    logic [3:0]          k_reg, k_next;
    logic [3:0]          j_reg, j_next;
    logic [3:0]          jd_reg;
    logic [AW-1:0]       acc_reg;

    // Point storage has no reset; contents survive until the next load.
    logic [PW-1:0]       point_mem [0:14];
    logic [PW-1:0]       point_q_reg;
    logic [14:0]         point_we;

    logic                load_fire;
    logic                data_return;
    logic signed [CW+PW-1:0] coef_ext;
    logic signed [CW+PW-1:0] point_ext;
    logic signed [CW+PW-1:0] product;
    logic [AW-1:0]       product_ext;

    assign load_fire = (state_reg == LOAD) && in_valid;

    // One write enable per point slot, selected by the load counter.
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_point_we
            assign point_we[gi] = load_fire && (ld_cnt_reg == 4'(gi));
        end
    endgenerate

    // Point file write plus registered read of point[j], so the read data
    // lines up with the ROM data returning one cycle after its address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 15; i++) begin
            if (!rst && point_we[i]) begin
                point_mem[i] <= in_data;
            end
        end
        if (state_reg == MAC) begin
            point_q_reg <= point_mem[j_reg];
        end
    end

    // Next-state and counter logic for the row/column sequencer.
    always_comb begin
        state_next  = state_reg;
        ld_cnt_next = ld_cnt_reg;
        k_next      = k_reg;
        j_next      = j_reg;
        case (state_reg)
            LOAD: begin
                if (in_valid) begin
                    ld_cnt_next = ld_cnt_reg + 4'd1;
                    if (ld_cnt_reg == 4'd14) begin
                        state_next = MAC;
                        k_next     = 4'd0;
                        j_next     = 4'd0;
                    end
                end
            end
            MAC: begin
                if (j_reg == 4'd14) begin
                    state_next = DRAIN;
                end else begin
                    j_next = j_reg + 4'd1;
                end
            end
            DRAIN: begin
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (k_reg == 4'd14) begin
                        state_next  = LOAD;
                        ld_cnt_next = 4'd0;
                        k_next      = 4'd0;
                        j_next      = 4'd0;
                    end else begin
                        state_next = MAC;
                        k_next     = k_reg + 4'd1;
                        j_next     = 4'd0;
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // State and counter registers; j_d tracks the column whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= LOAD;
            ld_cnt_reg <= 4'd0;
            k_reg      <= 4'd0;
            j_reg      <= 4'd0;
            jd_reg     <= 4'd0;
        end else begin
            state_reg  <= state_next;
            ld_cnt_reg <= ld_cnt_next;
            k_reg      <= k_next;
            j_reg      <= j_next;
            if (state_reg == MAC) begin
                jd_reg <= j_reg;
            end
        end
    end

    // Full-width signed product, sign-extended to the accumulator width.
    assign coef_ext    = {{PW{coef_data[CW-1]}}, coef_data};
    assign point_ext   = {{CW{point_q_reg[PW-1]}}, point_q_reg};
    assign product     = coef_ext * point_ext;
    assign product_ext = {{(AW-CW-PW){product[CW+PW-1]}}, product};

    assign data_return = ((state_reg == MAC) && (j_reg != 4'd0)) || (state_reg == DRAIN);

    // Accumulator: first column of a row overwrites, later columns add (mod 2^AW).
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (data_return) begin
            if (jd_reg == 4'd0) begin
                acc_reg <= product_ext;
            end else begin
                acc_reg <= acc_reg + product_ext;
            end
        end
    end

    assign coef_addr = ((state_reg == MAC) || (state_reg == DRAIN))
                     ? (({4'd0, k_reg} * 8'd15) + {4'd0, j_reg}) : 8'd0;
    assign in_ready  = (state_reg == LOAD);
    assign busy      = (state_reg != LOAD);
    assign out_valid = (state_reg == OUT);
    assign out_idx   = k_reg;
    assign out_data  = acc_reg;

endmodule

// File: tb/tb_toom8_interp_sequencer.sv
// Directed/randomized bench for toom8_interp_sequencer with a plain-arithmetic
// reference model of c_k = sum_j C[k][j] * p_j (mod 2^384).
module tb_toom8_interp_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [309:0] in_data;
    logic [7:0]   coef_addr;
    logic [63:0]  coef_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_idx;
    logic [383:0] out_data;
    logic         busy;

    logic [63:0]  rom   [0:224];
    logic [309:0] pts   [0:14];
    logic [383:0] exp_c [0:14];

    int checks = 0;
    int errors = 0;

    toom8_interp_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Coefficient ROM with one cycle of read latency.
    always @(posedge clk) begin
        coef_data <= rom[coef_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [309:0] rand_point();
        logic [309:0] r;
        r = '0;
        for (int w = 0; w < 10; w++) begin
            r = {r[277:0], 32'($urandom)};
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_coef();
        return {32'($urandom), 32'($urandom)};
    endfunction

    // Reference: signed dot product of each ROM row with the points, mod 2^384.
    function automatic void compute_model();
        logic [383:0] s, a, b;
        for (int k = 0; k < 15; k++) begin
            s = '0;
            for (int j = 0; j < 15; j++) begin
                a = {{320{rom[k*15+j][63]}}, rom[k*15+j]};
                b = {{74{pts[j][309]}}, pts[j]};
                s = s + a * b;
            end
            exp_c[k] = s;
        end
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < 225; i++) rom[i] = rand_coef();
        for (int j = 0; j < 15; j++) pts[j] = rand_point();
    endfunction

    // Feed p0..p14; with gaps, an idle cycle (garbage data) follows each point.
    task automatic load_block(input bit gaps);
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_data  = pts[i];
            step();
            if (gaps && i != 14) begin
                in_valid = 1'b0;
                in_data  = rand_point();
                step();
            end
        end
        in_valid = 1'b0;
        in_data  = rand_point();
    endtask

    // Collect 15 outputs; optional backpressure at row bp_k, optional timing checks.
    // Called at cycle E+1 where E is the edge that accepted p14.
    task automatic run_block(input int bp_k, input bit do_timing);
        int cyc;
        int total;
        bit stable;
        logic [383:0] held_data;
        logic [3:0]   held_idx;
        logic [7:0]   held_addr;
        total = 1;
        for (int k = 0; k < 15; k++) begin
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 200) begin
                if (do_timing && k == 0 && cyc < 15) check("row0_coef_addr", coef_addr, cyc);
                step();
                cyc++;
                total++;
            end
            check("out_valid_wait", out_valid, 1);
            if (do_timing && k == 0)  check("first_valid_cycle", total, 17);
            if (do_timing && k == 14) check("last_valid_cycle", total, 255);
            check("out_idx", out_idx, k);
            check("out_data", out_data, exp_c[k]);
            $display("xfer k=%0d idx=%0d data=%0h", k, out_idx, out_data);
            if (k == bp_k) begin
                out_ready = 1'b0;
                held_data = out_data;
                held_idx  = out_idx;
                held_addr = coef_addr;
                stable    = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    step();
                    total++;
                    if (out_valid !== 1'b1 || out_data !== held_data ||
                        out_idx !== held_idx || coef_addr !== held_addr) stable = 1'b0;
                end
                check("bp_hold_stable", stable, 1);
                out_ready = 1'b1;
            end
            step();
            total++;
            if (k == bp_k && k < 14) begin
                check("bp_resume_mac_addr", coef_addr, (k + 1) * 15);
                check("bp_resume_valid_low", out_valid, 0);
            end
        end
        check("reload_in_ready", in_ready, 1);
        check("reload_busy", busy, 0);
        if (do_timing) check("reload_cycle", total, 256);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 225; i++) rom[i] = '0;
        repeat (3) step();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_data", out_data, 0);
        check("rst_coef_addr", coef_addr, 0);
        rst = 1'b0;
        step();

        // Identity ROM, p_j = j+1
        for (int k = 0; k < 15; k++)
            for (int j = 0; j < 15; j++)
                rom[k*15+j] = (j == k) ? 64'd1 : 64'd0;
        for (int j = 0; j < 15; j++) pts[j] = 310'(j + 1);
        compute_model();
        load_block(1'b0);
        run_block(-1, 1'b0);

        // Constant ROM, unit points, with latency and address-order checks
        for (int i = 0; i < 225; i++) rom[i] = 64'd6227020800;
        for (int j = 0; j < 15; j++) pts[j] = 310'd1;
        compute_model();
        load_block(1'b0);
        run_block(-1, 1'b1);

        // Sign/width: C[3][13] = -1, p13 = -2^309
        for (int i = 0; i < 225; i++) rom[i] = '0;
        rom[3*15+13] = '1;
        for (int j = 0; j < 15; j++) pts[j] = rand_point();
        pts[13] = {1'b1, 309'd0};
        compute_model();
        load_block(1'b0);
        run_block(-1, 1'b0);

        // Random data with backpressure at row 3
        fill_random();
        compute_model();
        load_block(1'b0);
        run_block(3, 1'b0);

        // Same data, gapped load
        load_block(1'b1);
        run_block(-1, 1'b0);

        // Reset during the row-5 MAC, then a fresh block
        fill_random();
        compute_model();
        load_block(1'b0);
        n = 0;
        while (coef_addr !== 8'd78 && n < 500) begin
            step();
            n++;
        end
        check("reach_row5_mac", coef_addr, 78);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_point();
        step();
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("post_rst_in_ready", in_ready, 1);
        fill_random();
        compute_model();
        load_block(1'b0);
        run_block(-1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
